// File: rtl/twofish_q_perm_pipe_if.sv
// Handshake bundle for twofish_q_perm_pipe.
//   in_valid/in_ready/in_data/in_sel/in_tag    : upstream transaction
//   out_valid/out_ready/out_data/out_tag       : downstream result
// master: the environment driving transactions in and accepting results.
// slave : the permutation pipeline itself.
interface twofish_q_perm_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic [LANES-1:0]   in_sel;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/twofish_q_perm_pipe.sv
// Two-stage pipelined Twofish q0/q1 byte permutation, LANES bytes per beat.
// Each lane selects q0 (sel=0) or q1 (sel=1) using the nibble-table form.
// Stage 1 holds the first table round (a2, b2, sel); stage 2 holds the final
// byte y. The tag travels alongside unchanged. Stall-all valid/ready flow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of twofish_q_perm_pipe_if (in_* and out_* handshake)
module twofish_q_perm_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  twofish_q_perm_pipe_if.slave bus
);

  // Nibble tables; entry 0 is the most significant nibble.
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  // Entry idx sits at bits [4*(15-idx)+3 -: 4]; 4*(15-idx)+3 == {~idx, 2'b11}.
  function automatic logic [3:0] tbl_nib(input logic [63:0] tbl, input logic [3:0] idx);
    return tbl[{~idx, 2'b11} -: 4];
  endfunction

  // b-path mix: a ^ ROR4(b,1) ^ {a[0],3'b0}
  function automatic logic [3:0] mix_b(input logic [3:0] a, input logic [3:0] b);
    return a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
  endfunction

  // First round: byte x -> {a2, b2}
  function automatic logic [7:0] round1(input logic sel, input logic [7:0] x);
    logic [3:0] a1;
    logic [3:0] b1;
    a1 = x[7:4] ^ x[3:0];
    b1 = mix_b(x[7:4], x[3:0]);
    return {tbl_nib(sel ? Q1_T0 : Q0_T0, a1), tbl_nib(sel ? Q1_T1 : Q0_T1, b1)};
  endfunction

  // Second round: {a2, b2} -> y = {b4, a4}
  function automatic logic [7:0] round2(input logic sel, input logic [3:0] a2,
                                        input logic [3:0] b2);
    logic [3:0] a3;
    logic [3:0] b3;
    a3 = a2 ^ b2;
    b3 = mix_b(a2, b2);
    return {tbl_nib(sel ? Q1_T3 : Q0_T3, b3), tbl_nib(sel ? Q1_T2 : Q0_T2, a3)};
  endfunction

  logic                  en1;
  logic                  en2;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [LANES-1:0][3:0] a2_q, a2_d;
  logic [LANES-1:0][3:0] b2_q, b2_d;
  logic [LANES-1:0]      sel_q, sel_d;
  logic [TAG_W-1:0]      tag1_q, tag1_d;
  logic [TAG_W-1:0]      tag2_q, tag2_d;
  logic [LANES-1:0][7:0] y_q, y_d;
  logic [LANES-1:0][7:0] r1_n;
  logic [LANES-1:0][7:0] y_n;

  // Per-lane round logic, evaluated unconditionally; registers pick it up below.
  always_comb begin
    r1_n = '0;
    y_n  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      r1_n[i] = round1(bus.in_sel[i], bus.in_data[8*i +: 8]);
      y_n[i]  = round2(sel_q[i], a2_q[i], b2_q[i]);
    end
  end

  always_comb begin
    en2    = !v2_q || bus.out_ready;
    en1    = !v1_q || en2;
    v1_d   = en1 ? bus.in_valid : v1_q;
    v2_d   = en2 ? v1_q : v2_q;
    a2_d   = a2_q;
    b2_d   = b2_q;
    sel_d  = sel_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    y_d    = y_q;
    if (en1 && bus.in_valid) begin
      sel_d  = bus.in_sel;
      tag1_d = bus.in_tag;
      for (int unsigned i = 0; i < LANES; i++) begin
        a2_d[i] = r1_n[i][7:4];
        b2_d[i] = r1_n[i][3:0];
      end
    end
    if (en2 && v1_q) begin
      y_d    = y_n;
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      a2_q   <= '0;
      b2_q   <= '0;
      sel_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      y_q    <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      a2_q   <= a2_d;
      b2_q   <= b2_d;
      sel_q  <= sel_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      y_q    <= y_d;
    end
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = y_q;
  assign bus.out_tag   = tag2_q;

endmodule

// File: tb/tb_twofish_q_perm_pipe.sv
module tb_twofish_q_perm_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 4;
  localparam int NBP = 40;

  logic clk;
  logic rst_n;
  int checks;
  int errors;

  twofish_q_perm_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  twofish_q_perm_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model: tables as hex strings, index 0 first.
  string qt [2][4] = '{
    '{"817D6F320B59ECA4", "ECB81235F4A6709D", "BA5E6D90C8F32471", "D7F4126E9B3085CA"},
    '{"28BDF76E31940AC5", "1E2B4C376DA5F908", "4C75169A0ED82B3F", "B951C3DE647F208A"}
  };

  function automatic int unsigned tlook(int unsigned q, int unsigned t, int unsigned i);
    string s;
    int unsigned c;
    s = qt[q][t];
    c = int'(s.getc(int'(i)));
    if (c >= 65) return c - 55;
    return c - 48;
  endfunction

  function automatic logic [7:0] q_model(int unsigned q, logic [7:0] x);
    int unsigned a, b, ta, tb;
    a = int'(x) >> 4;
    b = int'(x) & 15;
    for (int r = 0; r < 2; r++) begin
      ta = a ^ b;
      tb = (a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((a & 1) << 3)) & 15;
      a = tlook(q, 2 * r, ta);
      b = tlook(q, 2 * r + 1, tb);
    end
    return 8'((b << 4) | a);
  endfunction

  function automatic logic [31:0] word_model(logic [31:0] d, logic [3:0] sel);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < 4; l++)
      w[8*l +: 8] = q_model(int'(sel[l]), d[8*l +: 8]);
    return w;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = '0;
    bus.in_tag   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%h expected v=0 d=00000000 t=0",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_q0_vector();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hF70F0100;
    bus.in_sel   = 4'b0000;
    bus.in_tag   = 4'h5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_tag   = 4'hF;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL q0_latency: got out_valid=%b expected 0 one cycle after accept", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h003867A9 || bus.out_tag !== 4'h5) begin
      errors++;
      $display("FAIL q0_vector: got v=%b d=%h t=%h expected v=1 d=003867a9 t=5",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL q0_no_dup_%0d: got out_valid=%b expected 0", k, bus.out_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_q1_vector();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000100;
    bus.in_sel   = 4'b1111;
    bus.in_tag   = 4'hA;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7575F375 || bus.out_tag !== 4'hA) begin
      errors++;
      $display("FAIL q1_vector: got v=%b d=%h t=%h expected v=1 d=7575f375 t=a",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [31:0] exp_w [256];
    bit seen [4][256];
    logic [31:0] d;
    logic [7:0] ob;
    for (int l = 0; l < 4; l++)
      for (int v = 0; v < 256; v++) seen[l][v] = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[k-2] || bus.out_tag !== 4'(k - 2)) begin
          errors++;
          $display("FAIL sweep_%0d: got v=%b d=%h t=%h expected v=1 d=%h t=%h",
                   k - 2, bus.out_valid, bus.out_data, bus.out_tag, exp_w[k-2], 4'(k - 2));
        end
        for (int l = 0; l < 4; l++) begin
          ob = bus.out_data[8*l +: 8];
          seen[l][ob] = 1'b1;
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_lead_%0d: got out_valid=%b expected 0", k, bus.out_valid);
        end
      end
      if (k < 256) begin
        for (int l = 0; l < 4; l++) d[8*l +: 8] = 8'(k + 64 * l);
        exp_w[k]     = word_model(d, 4'b0101);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = 4'b0101;
        bus.in_tag   = 4'(k);
      end else begin
        idle_inputs();
      end
    end
    for (int l = 0; l < 4; l++) begin
      int cnt;
      cnt = 0;
      for (int v = 0; v < 256; v++) if (seen[l][v]) cnt++;
      checks++;
      if (cnt != 256) begin
        errors++;
        $display("FAIL bijection_lane%0d: got %0d distinct outputs expected 256", l, cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [20];
    logic [31:0] d;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 23; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== ((k >= 2 && k < 22) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_valid_%0d: got %b expected %b", k, bus.out_valid,
                 (k >= 2 && k < 22) ? 1'b1 : 1'b0);
      end
      if (k >= 2 && k < 22) begin
        checks++;
        if (bus.out_data !== exp_w[k-2] || bus.out_tag !== 4'(k - 2)) begin
          errors++;
          $display("FAIL b2b_data_%0d: got d=%h t=%h expected d=%h t=%h", k - 2,
                   bus.out_data, bus.out_tag, exp_w[k-2], 4'(k - 2));
        end
      end
      if (k < 20) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready_%0d: got %b expected 1", k, bus.in_ready);
        end
        d = {8'(k + 128), 8'(k) ^ 8'h5A, ~8'(k), 8'(k * 7)};
        exp_w[k]     = word_model(d, 4'(k));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = 4'(k);
        bus.in_tag   = 4'(k);
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q_data [$];
    logic [3:0]  q_tag [$];
    logic [31:0] d;
    logic [31:0] held_d;
    logic [3:0]  held_t;
    logic        stalled;
    logic        exp_rdy;
    int sent, recv, occ, cyc;
    sent = 0; recv = 0; occ = 0; cyc = 0;
    stalled = 1'b0;
    held_d = '0;
    held_t = '0;
    while (recv < NBP && cyc < 800) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 99) < 30);
      if (sent < NBP && $urandom_range(0, 99) < 70) begin
        d = {8'(sent * 11), 8'(sent + 3), 8'(sent ^ 'h3C), 8'(sent * 5 + 1)};
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = 4'(sent * 3);
        bus.in_tag   = 4'(sent);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_sel   = 4'($urandom);
        bus.in_tag   = 4'($urandom);
      end
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_tag !== held_t) begin
          errors++;
          $display("FAIL bp_stable_%0d: got v=%b d=%h t=%h expected v=1 d=%h t=%h", cyc,
                   bus.out_valid, bus.out_data, bus.out_tag, held_d, held_t);
        end
      end
      exp_rdy = !(occ == 2 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready_%0d: got %b expected %b (occupancy %0d)", cyc,
                 bus.in_ready, exp_rdy, occ);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (q_data.size() == 0) begin
          errors++;
          $display("FAIL bp_dup_%0d: got output d=%h with nothing in flight expected none",
                   cyc, bus.out_data);
        end else begin
          if (bus.out_data !== q_data[0] || bus.out_tag !== q_tag[0]) begin
            errors++;
            $display("FAIL bp_data_%0d: got d=%h t=%h expected d=%h t=%h", recv,
                     bus.out_data, bus.out_tag, q_data[0], q_tag[0]);
          end
          void'(q_data.pop_front());
          void'(q_tag.pop_front());
          occ--;
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        q_data.push_back(word_model(bus.in_data, bus.in_sel));
        q_tag.push_back(bus.in_tag);
        sent++;
        occ++;
      end
      stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_d  = bus.out_data;
      held_t  = bus.out_tag;
      cyc++;
    end
    checks++;
    if (recv != NBP || sent != NBP || q_data.size() != 0) begin
      errors++;
      $display("FAIL bp_totals: got sent=%0d recv=%0d pending=%0d after %0d cycles expected %0d %0d 0",
               sent, recv, q_data.size(), cyc, NBP, NBP);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11223344;
    bus.in_sel    = 4'b1010;
    bus.in_tag    = 4'h1;
    @(posedge clk); #1;
    bus.in_data   = 32'h55667788;
    bus.in_tag    = 4'h2;
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got out_valid=%b in_ready=%b expected 1 0",
               bus.out_valid, bus.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 4'h0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: got v=%b d=%h t=%h rdy=%b expected 0 00000000 0 1",
               bus.out_valid, bus.out_data, bus.out_tag, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: got out_valid=%b expected 0", bus.out_valid);
    end
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0FF70100;
    bus.in_sel    = 4'b0011;
    bus.in_tag    = 4'h7;
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_ghost: got out_valid=%b expected 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3800F375 || bus.out_tag !== 4'h7) begin
      errors++;
      $display("FAIL mid_first_after_reset: got v=%b d=%h t=%h expected v=1 d=3800f375 t=7",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_tail: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_q0_vector();
    test_q1_vector();
    test_sweep();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
